// File: rtl/sprite_compositor_if.sv
// Pixel stream bus for sprite_compositor: raster position/background in,
// composited colour, winner index and collision flags out.
interface sprite_compositor_if #(
  parameter int NUM_SPRITES = 8,
  parameter int COLOR_W     = 4
);
  logic                     pix_valid;
  logic                     frame_start;
  logic [10:0]              draw_x;
  logic [9:0]               draw_y;
  logic [3*COLOR_W-1:0]     bg_rgb;
  logic [3*COLOR_W-1:0]     rgb_out;
  logic                     out_valid;
  logic [3:0]               hit_id;
  logic [NUM_SPRITES-1:0]   collision;

  modport master (
    output pix_valid, frame_start, draw_x, draw_y, bg_rgb,
    input  rgb_out, out_valid, hit_id, collision
  );

  modport slave (
    input  pix_valid, frame_start, draw_x, draw_y, bg_rgb,
    output rgb_out, out_valid, hit_id, collision
  );
endinterface

// File: rtl/sprite_compositor.sv
// Two-stage sprite compositor: hit test + ROM row fetch, then priority mux.
// Optional sticky overlap flags are built only when SPRITE_COLLISION_EN is defined.
module sprite_compositor #(
  parameter int NUM_SPRITES = 8,
  parameter int SPRITE_W    = 16,
  parameter int SPRITE_H    = 16,
  parameter int COLOR_W     = 4,
  localparam int RW = $clog2(SPRITE_H),
  localparam int CW = $clog2(SPRITE_W),
  localparam int CL = 3 * COLOR_W
) (
  input  logic                            clk,
  input  logic                            rst_n,
  sprite_compositor_if.slave              pix_if,
  input  logic [NUM_SPRITES-1:0]          sprite_en,
  input  logic [NUM_SPRITES*11-1:0]       sprite_pos_x,
  input  logic [NUM_SPRITES*10-1:0]       sprite_pos_y,
  input  logic [NUM_SPRITES*CL-1:0]       sprite_color,
  output logic [NUM_SPRITES*RW-1:0]       sprite_row_addr,
  input  logic [NUM_SPRITES*SPRITE_W-1:0] sprite_row_data
);

  logic                            valid1_d, valid1_q;
  logic [NUM_SPRITES-1:0]          hit_d, hit_q;
  logic [NUM_SPRITES-1:0][CW-1:0]  col_d, col_q;
  logic [CL-1:0]                   bg1_d, bg1_q;
  logic [NUM_SPRITES*RW-1:0]       row_addr;

  logic [10:0] px;
  logic [9:0]  py;
  logic [11:0] x_end;
  logic [10:0] y_end;

  // End coordinates carry one extra bit so edge sprites never wrap to 0.
  always_comb begin
    valid1_d = pix_if.pix_valid;
    bg1_d    = pix_if.bg_rgb;
    hit_d    = '0;
    col_d    = '0;
    row_addr = '0;
    px       = '0;
    py       = '0;
    x_end    = '0;
    y_end    = '0;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      px    = sprite_pos_x[i*11 +: 11];
      py    = sprite_pos_y[i*10 +: 10];
      x_end = {1'b0, px} + 12'(SPRITE_W);
      y_end = {1'b0, py} + 11'(SPRITE_H);
      if (pix_if.pix_valid && sprite_en[i] &&
          pix_if.draw_x >= px && {1'b0, pix_if.draw_x} < x_end &&
          pix_if.draw_y >= py && {1'b0, pix_if.draw_y} < y_end) begin
        hit_d[i]                = 1'b1;
        col_d[i]                = CW'(pix_if.draw_x - px);
        row_addr[i*RW +: RW]    = RW'(pix_if.draw_y - py);
      end
    end
  end

  // ROM address is combinational so the row returns alongside stage-1 state.
  assign sprite_row_addr = rst_n ? row_addr : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid1_q <= 1'b0;
      hit_q    <= '0;
      col_q    <= '0;
      bg1_q    <= '0;
    end else begin
      valid1_q <= valid1_d;
      hit_q    <= hit_d;
      col_q    <= col_d;
      bg1_q    <= bg1_d;
    end
  end

  logic [NUM_SPRITES-1:0] opaque;
  logic [SPRITE_W-1:0]    row;
  logic                   out_valid_d, out_valid_q;
  logic [CL-1:0]          rgb_d, rgb_q;
  logic [3:0]             hit_id_d, hit_id_q;

  always_comb begin
    opaque      = '0;
    row         = '0;
    out_valid_d = valid1_q;
    rgb_d       = '0;
    hit_id_d    = 4'hF;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      row       = sprite_row_data[i*SPRITE_W +: SPRITE_W];
      opaque[i] = hit_q[i] & row[col_q[i]];
    end
    if (valid1_q) begin
      rgb_d = bg1_q;
      // Descending scan so the lowest-index opaque sprite is written last.
      for (int unsigned i = NUM_SPRITES; i > 0; i--) begin
        if (opaque[i-1]) begin
          rgb_d    = sprite_color[(i-1)*CL +: CL];
          hit_id_d = 4'(i-1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      rgb_q       <= '0;
      hit_id_q    <= 4'hF;
    end else begin
      out_valid_q <= out_valid_d;
      rgb_q       <= rgb_d;
      hit_id_q    <= hit_id_d;
    end
  end

  assign pix_if.out_valid = out_valid_q;
  assign pix_if.rgb_out   = rgb_q;
  assign pix_if.hit_id    = hit_id_q;

`ifdef SPRITE_COLLISION_EN
  logic                   fs1_d, fs1_q;
  logic [NUM_SPRITES-1:0] coll_d, coll_q;

  // frame_start travels with its pixel so it clears at the same stage the
  // collisions of that pixel are recorded.
  always_comb begin
    fs1_d  = pix_if.frame_start;
    coll_d = fs1_q ? '0 : coll_q;
    if ((opaque & (opaque - NUM_SPRITES'(1))) != '0) begin
      coll_d = coll_d | opaque;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fs1_q  <= 1'b0;
      coll_q <= '0;
    end else begin
      fs1_q  <= fs1_d;
      coll_q <= coll_d;
    end
  end

  assign pix_if.collision = coll_q;
`else
  logic unused_frame_start;
  assign unused_frame_start = pix_if.frame_start;
  assign pix_if.collision   = '0;
`endif

endmodule
